seg_scan_decoder: RTL and testbench



---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_pattern_decode.sv | 22 ++
 rtl/seg_scan_decoder.sv | 93 +++++++++
 tb/tb_seg_scan_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: active-low abcdefg segment patterns, blank pattern and hex nibble type
package seg_pkg;
    typedef logic [3:0] nibble_t;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational lookup of an active-low 7-segment pattern to its hex nibble
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic       blank,
    output nibble_t    nibble
);
    // patterns are unique, so at most one table entry matches
    always_comb begin
        hit = 1'b0;
        nibble = '0;
        for (int v = 0; v < 16; v++) begin
            if (seg == SEG_TABLE[v]) begin
                hit = 1'b1;
                nibble = nibble_t'(v);
            end
        end
    end
    assign blank = seg == SEG_BLANK;
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounced recovery of hex digits from a multiplexed active-low 7-seg bus; SEG_SCAN_SYNC_EN selects a two-flop input synchroniser
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              a_to_g,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    frame_done
);
    import seg_pkg::*;
`ifdef SEG_SCAN_SYNC_EN
    localparam int NS = 2;
`else
    localparam int NS = 1;
`endif
    localparam int SW = NUM_DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] S = CW'(STABLE_CYCLES);

    logic [SW-1:0]         stg [NS];
    logic [SW-1:0]         prev;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0] s_an, sel, seen, seen_nxt;
    logic [6:0]            s_seg;
    logic                  changed, commit, hit, blank;
    nibble_t               nib;

    assign {s_an, s_seg} = stg[NS-1];
    assign changed  = stg[NS-1] != prev;
    assign cnt_nxt  = changed ? CW'(1) : cnt == S ? cnt : cnt + 1'b1;
    assign commit   = cnt_nxt == S && (changed || cnt != S) && $onehot(~s_an);
    assign sel      = commit ? ~s_an : '0;
    assign seen_nxt = (clear ? '0 : seen) | sel;

    seg_pattern_decode u_dec (
        .seg    (s_seg),
        .hit    (hit),
        .blank  (blank),
        .nibble (nib)
    );

    // capture pipeline resets to all ones (no anode enabled) so reset never looks like a digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) stg[k] <= '1;
            prev <= '1;
            cnt <= '0;
        end else begin
            stg[0] <= {an, a_to_g};
            for (int k = 1; k < NS; k++) stg[k] <= stg[k-1];
            prev <= stg[NS-1];
            cnt <= cnt_nxt;
        end
    end

    // digit commit and frame tracking; clear lands first so a same-cycle commit wins for its digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= '0;
            valid <= '0;
            err <= '0;
            seen <= '0;
            frame_done <= 1'b0;
        end else begin
            if (clear) begin
                valid <= '0;
                err <= '0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel[i]) begin
                    if (hit) begin
                        digits[4*i +: 4] <= nib;
                        valid[i] <= 1'b1;
                        err[i] <= 1'b0;
                    end else if (blank) begin
                        valid[i] <= 1'b0;
                        err[i] <= 1'b0;
                    end else begin
                        err[i] <= 1'b1;
                    end
                end
            end
            frame_done <= &seen_nxt;
            seen <= &seen_nxt ? '0 : seen_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed stimulus checked against a run-length display model and literal expectations
module tb_seg_scan_decoder;
    localparam int ND = 8;
    localparam int S  = 4;
`ifdef SEG_SCAN_SYNC_EN
    localparam int NS = 2;
`else
    localparam int NS = 1;
`endif

    logic          clk, rst_n, clear, frame_done;
    logic [ND-1:0] an, valid, err;
    logic [6:0]    a_to_g;
    logic [4*ND-1:0] digits;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .an         (an),
        .a_to_g     (a_to_g),
        .clear      (clear),
        .digits     (digits),
        .valid      (valid),
        .err        (err),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // model: a driven bus value held for exactly S edges is one commit, seen NS edges later
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_val, m_err, m_seen;
    logic            m_fd;
    logic [ND+6:0]   prevbus, bus;
    int              run, ev, idx, p;
    logic            hitv;
    int              evq [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_dig = '0;
            m_val = '0;
            m_err = '0;
            m_seen = '0;
            m_fd = 1'b0;
            run = 0;
            prevbus = '1;
            evq.delete();
            repeat (NS) evq.push_back(-1);
        end else begin
            bus = {an, a_to_g};
            run = (bus == prevbus) ? run + 1 : 1;
            prevbus = bus;
            ev = -1;
            if (run == S && $countones(~an) == 1)
                for (int d = 0; d < ND; d++) if (!an[d]) ev = d * 128 + int'(a_to_g);
            evq.push_back(ev);
            ev = evq.pop_front();
            m_fd = 1'b0;
            if (clear) begin
                m_val = '0;
                m_err = '0;
                m_seen = '0;
            end
            if (ev >= 0) begin
                idx = ev / 128;
                p = ev % 128;
                if (p == 127) begin
                    m_val[idx] = 1'b0;
                    m_err[idx] = 1'b0;
                end else begin
                    hitv = 1'b0;
                    for (int v = 0; v < 16; v++) begin
                        if (p == int'(tbl[v])) begin
                            hitv = 1'b1;
                            m_dig[4*idx +: 4] = 4'(v);
                        end
                    end
                    if (hitv) begin
                        m_val[idx] = 1'b1;
                        m_err[idx] = 1'b0;
                    end else begin
                        m_err[idx] = 1'b1;
                    end
                end
                m_seen[idx] = 1'b1;
                if (&m_seen) begin
                    m_fd = 1'b1;
                    m_seen = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("digits", digits, m_dig);
            check("valid", 32'(valid), 32'(m_val));
            check("err", 32'(err), 32'(m_err));
            check("frame_done", 32'(frame_done), 32'(m_fd));
        end
    end

    int fd_cnt = 0;
    logic fd_en = 1'b0;
    always @(negedge clk) if (fd_en && frame_done) fd_cnt++;

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input int n);
        an = a;
        a_to_g = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        an = 8'h00;
        a_to_g = 7'h2A;
        repeat (3) @(negedge clk);
        check("rst_digits", digits, 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        drive(8'hFF, 7'h7F, 20);
        check("idle_valid", 32'(valid), 32'h0);
        check("idle_digits", digits, 32'h0);

        drive(8'hFE, 7'b0010010, NS + S - 1);
        check("lat_early_valid0", 32'(valid[0]), 32'h0);
        drive(8'hFE, 7'b0010010, 1);
        check("lat_valid0", 32'(valid[0]), 32'h1);
        check("lat_digit0", 32'(digits[3:0]), 32'h2);
        drive(8'hFE, 7'b0010010, 10 - NS - S);
        drive(8'hFF, 7'h7F, 3);

        drive(8'hFD, 7'b0000110, 3);
        drive(8'hFF, 7'h7F, 6);
        check("glitch_digit1", 32'(digits[7:4]), 32'h0);
        check("glitch_valid1", 32'(valid[1]), 32'h0);
        drive(8'hFC, 7'b0000110, 10);
        drive(8'hFF, 7'h7F, 6);
        check("multi_valid", 32'(valid), 32'h01);
        check("multi_digits", digits, 32'h2);

        drive(8'hF7, 7'b1110111, 6);
        check("err3_set", 32'(err[3]), 32'h1);
        check("err3_digit", 32'(digits[15:12]), 32'h0);
        drive(8'hF7, 7'b0001000, 6);
        check("err3_clr", 32'(err[3]), 32'h0);
        check("digit3_A", 32'(digits[15:12]), 32'hA);
        check("valid3", 32'(valid[3]), 32'h1);
        drive(8'hFF, 7'h7F, 3);

        fd_en = 1'b1;
        for (int d = 0; d < ND; d++) drive(~(8'h01 << d), tbl[d], 5);
        drive(8'hFF, 7'h7F, NS + 2);
        fd_en = 1'b0;
        check("scan_digits", digits, 32'h7654_3210);
        check("scan_valid", 32'(valid), 32'hFF);
        check("scan_fd_count", 32'(fd_cnt), 32'h1);

        drive(8'hEF, 7'b1110111, 6);
        check("err4_set", 32'(err), 32'h10);
        clear = 1'b1;
        drive(8'hFF, 7'h7F, 1);
        clear = 1'b0;
        check("clr_valid", 32'(valid), 32'h0);
        check("clr_err", 32'(err), 32'h0);
        check("clr_digits", digits, 32'h7654_3210);

        drive(8'hFB, 7'b0000000, NS + S - 1);
        clear = 1'b1;
        drive(8'hFB, 7'b0000000, 1);
        clear = 1'b0;
        check("clrcommit_valid", 32'(valid), 32'h04);
        check("clrcommit_digit2", 32'(digits[11:8]), 32'h8);
        drive(8'hFB, 7'b0000000, 3);
        drive(8'hFF, 7'h7F, 3);

        drive(8'hDF, 7'b0000100, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_digits", digits, 32'h0);
        check("async_valid", 32'(valid), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(8'hDF, 7'b0000100, 10);
        check("post_rst_valid", 32'(valid), 32'h20);
        check("post_rst_digits", digits, 32'h0090_0000);
        drive(8'hFF, 7'h7F, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
